// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states,
// oversampling constants and the bit-timing divisor helper.
package uart_pkg;

    // Sample ticks per bit period; the receiver is built around 16x only.
    localparam int OVERSAMPLE = 16;

    // Mid-bit sample positions used for the 2-of-3 majority vote.
    localparam int SAMPLE_MID_LO = 7;
    localparam int SAMPLE_MID    = 8;
    localparam int SAMPLE_MID_HI = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Clock cycles per oversample tick. A divisor below 16 would give zero,
    // which is forced to one so the tick counter still advances.
    function automatic logic [31:0] tick_div_of(input logic [31:0] clk_div);
        return ((clk_div >> 4) == 32'd0) ? 32'd1 : (clk_div >> 4);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: latches the divisor at the start edge, then
// produces one tick every tick_div clocks and the sample position in the bit.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter  int OVERSAMPLE = 16,
    localparam int IDX_W      = $clog2(OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      clk_div,
    output logic             tick,
    output logic [IDX_W-1:0] sample_idx
);

    logic [31:0] tick_div_q;
    logic [31:0] tick_cnt_q;

    // Tick on the last count of the latched divisor.
    assign tick = (tick_cnt_q == tick_div_q - 32'd1);

    // Latch the divisor on start, count clocks into ticks and ticks into sample positions.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            tick_div_q <= 32'd1;
            tick_cnt_q <= '0;
            sample_idx <= '0;
        end else if (start) begin
            // A divisor change after this point has no effect on the frame.
            tick_div_q <= tick_div_of(clk_div);
            tick_cnt_q <= '0;
            sample_idx <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
            // OVERSAMPLE is a power of two, so 15 -> 0 wraps at the bit boundary.
            sample_idx <= sample_idx + 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver feeding the rx byte FIFO. Synchronises the
// pad input, majority-votes every bit and reports a good byte, a framing
// error or an overrun as a single-cycle pulse.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] clk_div,
    input  logic        rx,
    input  logic        fifo_full,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] IDX_LO  = IDX_W'(SAMPLE_MID_LO);
    localparam logic [IDX_W-1:0] IDX_MID = IDX_W'(SAMPLE_MID);
    localparam logic [IDX_W-1:0] IDX_HI  = IDX_W'(SAMPLE_MID_HI);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_sync;
    logic                   rx_prev_q;
    logic                   start_edge;
    logic                   tick;
    logic [IDX_W-1:0]       sample_idx;
    logic [1:0]             vote_q;
    logic                   resolve;
    logic                   majority;
    rx_state_e              state_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;

    // Bring the asynchronous pad into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the synchroniser resets to all ones (idle line) so leaving
        // reset can never look like a falling start edge.
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];

    // Previous synced level for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_sync;
        end
    end

    assign start_edge = (state_q == IDLE) && rx_prev_q && !rx_sync;

    uart_rx_tick_gen #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_edge),
        .clk_div    (clk_div),
        .tick       (tick),
        .sample_idx (sample_idx)
    );

    // Capture the first two mid-bit samples; the third is taken live at resolve time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= '0;
        end else if (tick && (sample_idx == IDX_LO)) begin
            vote_q[0] <= rx_sync;
        end else if (tick && (sample_idx == IDX_MID)) begin
            vote_q[1] <= rx_sync;
        end
    end

    assign resolve  = tick && (sample_idx == IDX_HI);
    assign majority = (vote_q[0] & vote_q[1]) |
                      (vote_q[0] & rx_sync)   |
                      (vote_q[1] & rx_sync);

    // Frame state machine with registered byte and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle, so each one lasts exactly
            // one clock whatever the tick rate.
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q <= START;
                    end
                end

                START: begin
                    if (resolve) begin
                        bit_cnt_q <= '0;
                        // A high majority means the low level was only a glitch.
                        state_q   <= majority ? IDLE : DATA;
                    end
                end

                DATA: begin
                    if (resolve) begin
                        shift_q   <= {majority, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (resolve) begin
                        if (!majority) begin
                            frame_err <= 1'b1;
                            state_q   <= BREAK;
                        end else if (fifo_full) begin
                            overrun <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            rx_data  <= shift_q;
                            rx_valid <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                end

                BREAK: begin
                    // Hold off until the line idles so a stuck-low line cannot retrigger.
                    if (rx_sync) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: a table of framed bytes plus
// hand-written corner-case sequences, with a scoreboard of expected pulses.
module tb_uart_rx_oversample;

    typedef enum logic [1:0] {EV_VALID, EV_FERR, EV_OVR} ev_kind_e;

    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [31:0] clk_div;
        int          bit_clks;
        logic [7:0]  data;
        bit          stop_low;
        bit          full;
        ev_kind_e    kind;
        logic [7:0]  data_after;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] clk_div = 32'd4166;
    logic        tx_line = 1'b1;
    logic        glitch = 1'b0;
    logic        rx;
    logic        fifo_full = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_cyc = -1;
    ev_t exp_q[$];

    assign rx = tx_line ^ glitch;

    uart_rx_oversample #(
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_div   (clk_div),
        .rx        (rx),
        .fifo_full (fifo_full),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input ev_kind_e kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Serial frame: start, 8 data bits LSB first, stop (optionally held low
    // for three bit times before releasing), then idle bits.
    task automatic send(input logic [7:0] data, input int bit_clks,
                        input bit stop_low, input int idle_bits);
        start_cyc = cyc;
        tx_line = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tx_line = data[i];
            repeat (bit_clks) @(negedge clk);
        end
        if (stop_low) begin
            tx_line = 1'b0;
            repeat (3 * bit_clks) @(negedge clk);
            check("busy_while_line_low", busy, 1);
            tx_line = 1'b1;
            repeat (8) @(negedge clk);
            check("busy_after_release", busy, 0);
        end else begin
            tx_line = 1'b1;
            repeat (bit_clks) @(negedge clk);
        end
        repeat (idle_bits * bit_clks) @(negedge clk);
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // Scoreboard: every observed pulse must match the oldest expected event.
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin : monitor
        logic [1:0] npulse;
        ev_kind_e   kind;
        ev_t        e;
        npulse = {1'b0, rx_valid} + {1'b0, frame_err} + {1'b0, overrun};
        if (npulse != 2'd0) begin
            check("pulse_exclusive", npulse, 1);
            check("pulse_one_cycle", prev_pulse, 0);
            if (rx_valid) begin
                kind = EV_VALID;
                valid_cyc = cyc;
            end else if (frame_err) begin
                kind = EV_FERR;
            end else begin
                kind = EV_OVR;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", kind, 3);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", kind, e.kind);
                if (kind == EV_VALID) check("rx_data", rx_data, e.data);
            end
        end
        prev_pulse = (npulse != 2'd0);
    end

    initial begin : main
        vec_t vecs[5];
        int   lat;

        vecs[0] = '{32'd160, 160, 8'h3C, 1'b1, 1'b0, EV_FERR,  8'hA5};
        vecs[1] = '{32'd160, 160, 8'h55, 1'b0, 1'b1, EV_OVR,   8'hA5};
        vecs[2] = '{32'd160, 160, 8'hC3, 1'b0, 1'b0, EV_VALID, 8'hC3};
        vecs[3] = '{32'd15,  16,  8'h5A, 1'b0, 1'b0, EV_VALID, 8'h5A};
        vecs[4] = '{32'd200, 192, 8'hE7, 1'b0, 1'b0, EV_VALID, 8'hE7};

        // Reset state
        repeat (5) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);

        // Real baud rate, divisor changed mid-frame, latency to mid-stop-bit
        expect_ev(EV_VALID, 8'hA5);
        fork
            send(8'hA5, 4166, 1'b0, 1);
            begin
                repeat (5 * 4166) @(negedge clk);
                clk_div = 32'd160;
            end
        join
        wait_drained("a5_pulse_seen");
        lat = valid_cyc - start_cyc;
        check("a5_latency_mid_stop", (lat >= 9 * 4166 + 4166 / 4) && (lat <= 10 * 4166 - 4166 / 8), 1);
        check("a5_rx_data", rx_data, 8'hA5);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            clk_div   = vecs[v].clk_div;
            fifo_full = vecs[v].full;
            expect_ev(vecs[v].kind, vecs[v].data);
            send(vecs[v].data, vecs[v].bit_clks, vecs[v].stop_low, 2);
            wait_drained($sformatf("vec%0d_pulse_seen", v));
            check($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].data_after);
            check($sformatf("vec%0d_busy", v), busy, 0);
            fifo_full = 1'b0;
        end

        // False start: low glitch shorter than the first vote sample
        clk_div = 32'd160;
        tx_line = 1'b0;
        repeat (20) @(negedge clk);
        check("false_start_busy_rises", busy, 1);
        repeat (20) @(negedge clk);
        tx_line = 1'b1;
        repeat (200) @(negedge clk);
        check("false_start_busy_falls", busy, 0);
        check("false_start_rx_data", rx_data, 8'hE7);

        // Single-sample glitch across the middle vote sample of data bit 2
        expect_ev(EV_VALID, 8'h00);
        fork
            send(8'h00, 160, 1'b0, 1);
            begin
                repeat (565) @(negedge clk);
                glitch = 1'b1;
                repeat (10) @(negedge clk);
                glitch = 1'b0;
            end
        join
        wait_drained("glitch_pulse_seen");
        check("glitch_rx_data", rx_data, 8'h00);

        // Overrun, then a back-to-back frame once the FIFO drains
        fifo_full = 1'b1;
        expect_ev(EV_OVR, 8'h55);
        send(8'h55, 160, 1'b0, 0);
        fifo_full = 1'b0;
        check("overrun_rx_data_hold", rx_data, 8'h00);
        expect_ev(EV_VALID, 8'h12);
        send(8'h12, 160, 1'b0, 1);
        wait_drained("b2b_pulse_seen");
        check("b2b_rx_data", rx_data, 8'h12);

        // Reset during data bit 4 aborts the frame silently
        fork
            send(8'hFF, 160, 1'b0, 1);
            begin
                repeat (880) @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                check("abort_rx_data_reset", rx_data, 8'h00);
                check("abort_busy", busy, 0);
                rst_n = 1'b1;
            end
        join
        check("abort_no_pulse", exp_q.size(), 0);
        expect_ev(EV_VALID, 8'h81);
        send(8'h81, 160, 1'b0, 1);
        wait_drained("after_abort_pulse_seen");
        check("after_abort_rx_data", rx_data, 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
